serial_wide_adder: RTL
======================

# serial_wide_adder

Byte-serial unsigned adder that builds an N-byte sum from a stream of 8-bit operand pairs. It sits directly downstream of the 8-bit unsigned adder stage: each accepted byte pair is added with the carry held from the previous byte, so operands wider than 8 bits can use one 8-bit add path. The result and the final carry are presented on a valid/ready output port.

## Interface

Parameters:

- NBYTES, default 4: number of operand bytes per operation; minimum 1.

Ports:

- CLK  input  1  Single clock; all state updates on the rising edge.
- RST_N  input  1  Reset, asynchronous and active-low.
- ABORT  input  1  Synchronous clear of any operation in progress.
- IN_VALID  input  1  A/B byte pair is valid.
- IN_READY  output  1  Block accepts a byte pair this cycle.
- A  input  8  Operand A byte, least-significant byte first.
- B  input  8  Operand B byte, least-significant byte first.
- OUT_VALID  output  1  RESULT/CO hold a completed sum.
- OUT_READY  input  1  Downstream consumes the result.
- RESULT  output  8*NBYTES  Sum; byte k comes from the k-th accepted pair.
- CO  output  1  Carry out of the most-significant byte.
- BUSY  output  1  At least one byte of the current operation has been accepted.

## Operation

- The FSM has two states:
  - ACCUM: IN_READY=1, OUT_VALID=0.
  - HOLD: IN_READY=0, OUT_VALID=1.
- Internal state:
  - byte counter CNT, range 0..NBYTES-1, width max(1, clog2(NBYTES)).
  - carry register C.
- Accept rule: a byte is accepted when IN_VALID && IN_READY on a clock edge.
- On accept in ACCUM:
  - Compute S[8:0] = A + B + C, unsigned, 9-bit, no truncation before bit 8.
  - RESULT[8*CNT+7 : 8*CNT] <= S[7:0].
  - C <= S[8].
  - If CNT < NBYTES-1: CNT increments and the state stays ACCUM.
  - If CNT == NBYTES-1: CO <= S[8], CNT <= 0, C <= 0, and the state moves to HOLD.
- In HOLD, on OUT_VALID && OUT_READY: the state returns to ACCUM. RESULT and CO keep their values until the next operation overwrites them.
- With NBYTES=1, every accepted pair goes straight to HOLD. The carry-in is always 0.
- BUSY = (state==ACCUM) && (CNT != 0).
- While IN_VALID=0 in ACCUM, nothing changes. Gaps between bytes are allowed and have no length limit.
- A and B are ignored when IN_VALID=0 or IN_READY=0.
- ABORT, checked at the clock edge, has priority over every other event in the same cycle:
  - State goes to ACCUM; CNT <= 0; C <= 0.
  - Any byte presented in that same cycle is discarded.
  - A pending result in HOLD is dropped.
  - RESULT and CO are not cleared.
- Reset (RST_N=0), applied asynchronously at any time, including mid-operation or in HOLD:
  - State goes to ACCUM; CNT=0; C=0.
  - RESULT=0; CO=0.
  - OUT_VALID=0; IN_READY=1; BUSY=0.
- Outputs are released on the first clock edge after RST_N rises.

## Timing

- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
  - IN_READY does not depend on OUT_READY in the same cycle.
- Latency: OUT_VALID rises in the cycle after the edge that accepts byte NBYTES-1.
- Minimum period per operation is NBYTES+1 cycles:
  - NBYTES accept cycles, then at least 1 HOLD cycle.
  - The next byte can be accepted in the cycle after the output handshake.
- Backpressure: while OUT_READY=0 in HOLD, OUT_VALID stays 1 and RESULT/CO stay stable.
- CO reflects only the carry of the most-significant byte. Intermediate carries are not visible on any port.

## Test plan

- Reset values: assert RST_N=0 mid-operation after 2 bytes, then release. Required: OUT_VALID=0, IN_READY=1, BUSY=0, RESULT=0, CO=0. The next 4 bytes form a fresh operation.
- Basic sum, NBYTES=4: 0x12345678 + 0x11111111, sent as LSB-first pairs (78,11), (56,11), (34,11), (12,11). Required: RESULT=0x23456789, CO=0, OUT_VALID one cycle after the 4th accept.
- Full carry ripple: 0xFFFFFFFF + 0x00000001, sent as (FF,01), (FF,00), (FF,00), (FF,00). Required: RESULT=0x00000000, CO=1. Also 0xFFFFFFFF + 0xFFFFFFFF gives RESULT=0xFFFFFFFE, CO=1.
- Gaps and backpressure:
  - Insert 3 idle cycles (IN_VALID=0) between bytes. Required: the sum is unchanged.
  - Hold OUT_READY=0 for 5 cycles in HOLD. Required: OUT_VALID=1, IN_READY=0, RESULT/CO stable; bytes presented during HOLD are not accepted.
- ABORT:
  - After 2 bytes of (FF,01), (FF,00), assert ABORT together with a valid byte. Required: that byte is dropped, BUSY=0, carry cleared. A following operation 0x00000001 + 0x00000001 gives 0x00000002, CO=0.
  - Assert ABORT in HOLD. Required: OUT_VALID falls the next cycle.
- NBYTES=1 build: (FF,FF). Required: RESULT=0xFE, CO=1, OUT_VALID the next cycle. Back-to-back operations sustain one result every 2 cycles with OUT_READY=1.

Source files
------------

// File: rtl/serial_wide_adder.sv
// Byte-serial unsigned adder: accumulates NBYTES operand byte pairs LSB-first
// through one 8-bit add path and presents the wide sum on a valid/ready port.
module serial_wide_adder #(
  parameter int NBYTES = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ABORT,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [7:0]            A,
  input  logic [7:0]            B,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [8*NBYTES-1:0]   RESULT,
  output logic                  CO,
  output logic                  BUSY
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 c_q, c_d;
  logic [8*NBYTES-1:0]  result_q, result_d;
  logic                 co_q, co_d;
  logic [8:0]           sum;
  logic                 last;

  always_comb begin
    sum      = {1'b0, A} + {1'b0, B} + {8'd0, c_q};
    last     = (cnt_q == CW'(NBYTES - 1));
    state_d  = state_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    result_d = result_q;
    co_d     = co_q;

    // ABORT outranks both the byte accept and the output handshake.
    if (ABORT) begin
      state_d = ACCUM;
      cnt_d   = '0;
      c_d     = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (IN_VALID) begin
            for (int k = 0; k < NBYTES; k++) begin
              if (cnt_q == CW'(k)) result_d[8*k +: 8] = sum[7:0];
            end
            if (last) begin
              co_d    = sum[8];
              c_d     = 1'b0;
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              c_d   = sum[8];
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (OUT_READY) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ACCUM;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      co_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      result_q <= result_d;
      co_q     <= co_d;
    end
  end

  // All outputs decode registered state only; IN_READY ignores OUT_READY.
  assign IN_READY  = (state_q == ACCUM);
  assign OUT_VALID = (state_q == HOLD);
  assign BUSY      = (state_q == ACCUM) && (cnt_q != '0);
  assign RESULT    = result_q;
  assign CO        = co_q;

endmodule
